// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer.
//   seq_state_t          : sequencer FSM states
//   DEFAULT_LENGTH       : default tap count
//   DEFAULT_MULT_LATENCY : default multiplier pipeline depth
//   wrap_sub(a, b, len)  : (a - b) modulo len, for a, b < len
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } seq_state_t;

  localparam int unsigned DEFAULT_LENGTH       = 6;
  localparam int unsigned DEFAULT_MULT_LATENCY = 3;

  // Modular subtraction. This works for any len, including lengths that
  // are not a power of two.
  function automatic int unsigned wrap_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned len);
    return (a >= b) ? (a - b) : (a + len - b);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_strobe_delay_line.sv
// Fixed-depth shift register used to delay strobes.
//   clk : clock
//   rst : synchronous active-high reset; clears every stage
//   d   : WIDTH-bit input, sampled every cycle
//   q   : d delayed by DEPTH cycles
module strobe_delay_line #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control sequencer for the FIR datapath.
// It accepts one sample at a time and writes that sample into the circular
// sample buffer. It then walks all LENGTH taps. Issue strobes are delayed
// through the multiplier latency so they enable the accumulator. The
// finished result is presented with a valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : sample offer / sequencer can accept
//   wr_en, wr_addr       : sample-buffer write strobe and slot
//   coef_addr            : coefficient register-file address
//   sample_addr          : sample-buffer read address matching coef_addr
//   issue_en             : multiplier operands valid this cycle
//   acc_en, acc_clear    : accumulator capture / load instead of add
//   out_valid, out_ready : result handshake
//   busy                 : sequencer not idle
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned LENGTH       = DEFAULT_LENGTH,
  parameter int unsigned MULT_LATENCY = DEFAULT_MULT_LATENCY,
  parameter int unsigned ADDRESS_BIT  = $clog2(LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDRESS_BIT-1:0] wr_addr,
  output logic [ADDRESS_BIT-1:0] coef_addr,
  output logic [ADDRESS_BIT-1:0] sample_addr,
  output logic                   issue_en,
  output logic                   acc_clear,
  output logic                   acc_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int unsigned DRAIN_BIT = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam logic [ADDRESS_BIT-1:0] LAST_TAP   = ADDRESS_BIT'(LENGTH - 1);
  localparam logic [DRAIN_BIT-1:0]   LAST_DRAIN = DRAIN_BIT'(MULT_LATENCY - 1);

  seq_state_t             state;
  logic [ADDRESS_BIT-1:0] wr_ptr;
  logic [ADDRESS_BIT-1:0] newest;
  logic [ADDRESS_BIT-1:0] k;
  logic [DRAIN_BIT-1:0]   drain_cnt;
  logic [1:0]             strobe_in;
  logic [1:0]             strobe_out;

  // in_ready is high exactly in IDLE, so the write strobe follows the offer
  // in the same cycle.
  assign wr_en   = in_ready & in_valid;
  assign wr_addr = wr_ptr;

  // Bit 1 is the issue strobe. Bit 0 marks the first tap so the
  // accumulator restarts on that product.
  assign strobe_in = {issue_en, issue_en && (k == '0)};
  assign acc_en    = strobe_out[1];
  assign acc_clear = strobe_out[0];

  strobe_delay_line #(
    .WIDTH (2),
    .DEPTH (MULT_LATENCY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (strobe_in),
    .q   (strobe_out)
  );

  // Address outputs are registered one step ahead of k. They therefore
  // line up with the MAC cycle they describe and hold their values outside
  // MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      newest      <= '0;
      k           <= '0;
      drain_cnt   <= '0;
      coef_addr   <= '0;
      sample_addr <= '0;
      in_ready    <= 1'b1;
      issue_en    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            newest      <= wr_ptr;
            wr_ptr      <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
            k           <= '0;
            coef_addr   <= '0;
            sample_addr <= wr_ptr;
            issue_en    <= 1'b1;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= MAC;
          end
        end
        MAC: begin
          if (k == LAST_TAP) begin
            issue_en  <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            k           <= k + 1'b1;
            coef_addr   <= k + 1'b1;
            sample_addr <= ADDRESS_BIT'(wrap_sub(32'(newest), 32'(k) + 32'd1, LENGTH));
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          issue_en  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with default parameters.
// A behavioural datapath uses the DUT addresses and strobes. It models the
// sample buffer, a 3-stage multiplier and the accumulator. Each result is
// compared against a direct convolution of the sample history.
module tb_fir_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] coef_addr;
  logic [2:0] sample_addr;
  logic       issue_en;
  logic       acc_clear;
  logic       acc_en;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fir_tap_sequencer #(
    .LENGTH       (6),
    .MULT_LATENCY (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .coef_addr   (coef_addr),
    .sample_addr (sample_addr),
    .issue_en    (issue_en),
    .acc_clear   (acc_clear),
    .acc_en      (acc_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural datapath model
  int coef [6] = '{3, -1, 4, 1, -5, 9};
  int sbuf [6] = '{0, 0, 0, 0, 0, 0};
  int pipe [3] = '{0, 0, 0};
  int acc = 0;
  int cur_sample = 0;
  int hist [$];

  always @(posedge clk) begin
    if (wr_en) sbuf[int'(wr_addr)] <= cur_sample;
    pipe[0] <= issue_en ? coef[int'(coef_addr)] * sbuf[int'(sample_addr)] : 0;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    if (acc_en) acc <= acc_clear ? pipe[2] : acc + pipe[2];
  end

  function automatic int conv();
    int y = 0;
    for (int j = 0; j < 6; j++) begin
      if (j < hist.size()) y += coef[j] * hist[j];
    end
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction. The sample is offered in cycle 0. out_ready is
  // held low for `stall` cycles after out_valid rises. in_valid stays high
  // throughout when hold_valid is set.
  task automatic do_sample(input int exp_wr, input int stall, input bit hold_valid);
    int y;
    @(negedge clk);
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    cur_sample = int'($urandom_range(0, 255));
    #1;
    chk("c0_in_ready", in_ready, 1);
    chk("c0_wr_en", wr_en, 1);
    chk("c0_wr_addr", wr_addr, exp_wr);
    hist.push_front(cur_sample);
    y = conv();
    for (int c = 1; c <= 10 + stall; c++) begin
      @(negedge clk);
      in_valid  = hold_valid;
      out_ready = (c >= 10 + stall);
      #1;
      chk("issue_en", issue_en, (c <= 6));
      if (c <= 6) begin
        chk("coef_addr", coef_addr, c - 1);
        chk("sample_addr", sample_addr, (exp_wr - (c - 1) + 6) % 6);
      end
      chk("acc_en", acc_en, (c >= 4 && c <= 9));
      chk("acc_clear", acc_clear, (c == 4));
      chk("out_valid", out_valid, (c >= 10));
      chk("in_ready_busy", in_ready, 0);
      chk("wr_en_busy", wr_en, 0);
      chk("busy", busy, 1);
      if (c == 10 + stall) chk("result", acc, y);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_issue_en", issue_en, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_en", wr_en, 0);

    // Seven back-to-back samples: the write slot wraps 0..5 then back to 0.
    do_sample(0, 0, 1'b0);
    do_sample(1, 0, 1'b0);
    do_sample(2, 0, 1'b0);
    do_sample(3, 0, 1'b0);
    do_sample(4, 0, 1'b0);
    do_sample(5, 0, 1'b0);
    do_sample(0, 0, 1'b0);

    // Backpressure with in_valid held. The next sample goes in right after
    // the handshake.
    do_sample(1, 4, 1'b1);
    do_sample(2, 0, 1'b0);

    // Reference-model run with random stalls.
    do_sample(3, int'($urandom_range(0, 2)), 1'b0);
    do_sample(4, int'($urandom_range(0, 2)), 1'b0);
    do_sample(5, int'($urandom_range(0, 2)), 1'b1);
    do_sample(0, int'($urandom_range(0, 2)), 1'b0);
    do_sample(1, int'($urandom_range(0, 2)), 1'b1);
    do_sample(2, int'($urandom_range(0, 2)), 1'b0);

    // Idle gap: nothing is accepted without in_valid.
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_wr_addr", wr_addr, 3);

    // Reset in MAC while k is 3.
    @(negedge clk);
    in_valid   = 1'b1;
    cur_sample = 17;
    #1;
    chk("r_wr_addr", wr_addr, 3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 4) rst = 1'b1;
      #1;
      chk("r_coef_addr", coef_addr, c - 1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("r_in_ready", in_ready, 1);
    chk("r_issue_en", issue_en, 0);
    chk("r_busy", busy, 0);
    chk("r_out_valid", out_valid, 0);
    chk("r_wr_addr0", wr_addr, 0);
    chk("r_acc_en", acc_en, 0);
    chk("r_acc_clear", acc_clear, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("r_acc_en_after", acc_en, 0);
      chk("r_acc_clear_after", acc_clear, 0);
      chk("r_out_valid_after", out_valid, 0);
      chk("r_issue_after", issue_en, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
